// File: rtl/otter_arb_pkg.sv
// rtl/otter_arb_pkg.sv - shared types and constants for the OTTER memory arbiter
//
// Purpose: state and owner encodings used by otter_mem_arbiter, plus the
//          all-ones byte-enable pattern driven for instruction fetches.
// Ports:   none (package).

package otter_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    // Wide enough for any DW up to 512; the arbiter slices off DW/8 bits.
    localparam int          FETCH_BE_MAXW = 64;
    localparam logic [63:0] FETCH_BE_ALL  = '1;

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// rtl/otter_arb_starve_ctr.sv - saturating count of data grants taken while fetch waits
//
// Purpose: counts data grants issued while a fetch is pending; once the count
//          reaches STARVE_MAX, hit stays high until a fetch grant clears it.
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   inc         a data grant happened this cycle while if_req was pending
//   clr         a fetch grant happened this cycle
//   hit         count has reached STARVE_MAX; fetch must win next arbitration

module otter_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    // A limit of zero would make the counter meaningless; treat it as one.
    localparam int LIM = (STARVE_MAX < 1) ? 1 : STARVE_MAX;
    localparam int CW  = $clog2(LIM + 1);
    localparam logic [CW-1:0] LIM_C = CW'(LIM);

    logic [CW-1:0] count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != LIM_C)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign hit = (count_q == LIM_C);

endmodule

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - IF/MEM arbiter for the shared single-port OTTER memory
//
// Purpose: one outstanding transaction at a time between instruction fetch
//          and data memory; data wins ties. Optional fetch anti-starvation
//          guard enabled by defining OTTER_ARB_STARVE_GUARD_EN.
// Ports:
//   CLK, RST_N                          clock, asynchronous active-low reset
//   if_req/if_addr/if_kill              fetch request, address, flush
//   if_rdata/if_valid                   fetch response
//   d_req/d_we/d_addr/d_wdata/d_be      data request
//   d_rdata/d_valid                     data response (loads and stores)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be/mem_gnt            memory request channel
//   mem_rvalid/mem_rdata                memory response channel
//   stall_F/stall_M                     pipeline stall outputs

module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_F,
    output logic            stall_M
);

    localparam int BEW = DW / 8;
    localparam logic [BEW-1:0] FETCH_BE = FETCH_BE_ALL[BEW-1:0];

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    logic       kill_q, kill_d;

    arb_owner_t winner;
    arb_owner_t sel_owner;
    logic       starve_hit;
    logic       req_int;
    logic       grant;
    logic       rsp;

    // Arbitration is only consulted in IDLE; a locked owner is never preempted.
    always_comb begin
        winner = OWN_NONE;
        if (starve_hit && if_req) begin
            winner = OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end else if (if_req) begin
            winner = OWN_I;
        end
    end

    assign sel_owner = (state_q == ST_IDLE) ? winner : owner_q;

    // IDLE issues the winner combinationally so a granted request costs no
    // extra cycle. Reset masks it so the memory sees nothing while held.
    assign req_int = RST_N &&
                     (((state_q == ST_IDLE) && (winner != OWN_NONE)) ||
                      (state_q == ST_REQ));
    assign grant   = req_int && mem_gnt;
    assign rsp     = (state_q == ST_WAIT) && mem_rvalid;

`ifdef OTTER_ARB_STARVE_GUARD_EN
    logic data_gnt;
    logic fetch_gnt;

    assign data_gnt  = grant && (sel_owner == OWN_D);
    assign fetch_gnt = grant && (sel_owner == OWN_I);

    otter_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (data_gnt && if_req),
        .clr   (fetch_gnt),
        .hit   (starve_hit)
    );
`else
    // Strict data priority: the fetch is never forced ahead of data.
    assign starve_hit = (STARVE_MAX < 0);
`endif

    always_comb begin
        mem_req   = req_int;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (req_int) begin
            case (sel_owner)
                OWN_D: begin
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    mem_be    = d_be;
                end
                OWN_I: begin
                    mem_addr  = if_addr;
                    mem_be    = FETCH_BE;
                end
                default: begin
                end
            endcase
        end
    end

    // A kill arriving together with the response suppresses it as well as a
    // kill recorded earlier in the transaction.
    assign if_valid = rsp && (owner_q == OWN_I) && !kill_q && !if_kill;
    assign d_valid  = rsp && (owner_q == OWN_D);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign d_rdata  = d_valid  ? mem_rdata : '0;

    assign stall_F = if_req & ~if_valid;
    assign stall_M = d_req  & ~d_valid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        kill_d  = kill_q;

        if ((state_q != ST_IDLE) && (owner_q == OWN_I) && if_kill) begin
            kill_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (winner != OWN_NONE) begin
                    owner_d = winner;
                    state_d = mem_gnt ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // No new request here: the slot after the response is idle.
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    kill_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - self-checking bench for otter_mem_arbiter

module tb_otter_mem_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int BEW        = DW / 8;
    localparam int STARVE_MAX = 4;

`ifdef OTTER_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            if_req, if_kill, if_valid;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            d_req, d_we, d_valid;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata, d_rdata;
    logic [BEW-1:0]  d_be;
    logic            mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [BEW-1:0]  mem_be;
    logic            stall_F, stall_M;

    otter_mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_F(stall_F), .stall_M(stall_M)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; if_kill = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        d_req, if_req, d_we;
        logic        exp_req, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_be;
        logic        exp_sf, exp_sm;
    } vec_t;

    vec_t vecs[6];

    // Random-phase reference: one outstanding transaction record.
    int m_phase;   // 0 none, 1 presented not granted, 2 granted awaiting response
    int m_owner;   // 0 none, 1 fetch, 2 data
    int m_kill, m_lat, m_streak;
    int win, cur;
    logic e_req, rsp, e_ifv, e_dv, f_done, d_done;
    int dgr, fetch_at, ifv_cnt;

    initial begin
        idle_inputs();
        RST_N = 0;

        vecs[0] = '{0, 0, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0};
        vecs[1] = '{0, 1, 0, 1, 0, 32'h100,  32'h0,        4'hF, 1, 0};
        vecs[2] = '{1, 0, 0, 1, 0, 32'h2000, 32'h0,        4'h3, 0, 1};
        vecs[3] = '{1, 0, 1, 1, 1, 32'h2000, 32'hCAFEF00D, 4'h3, 0, 1};
        vecs[4] = '{1, 1, 0, 1, 0, 32'h2000, 32'h0,        4'h3, 1, 1};
        vecs[5] = '{1, 1, 1, 1, 1, 32'h2000, 32'hCAFEF00D, 4'h3, 1, 1};

        // Reset state
        #3;
        chk1("rst_mem_req", mem_req, 0);
        chk1("rst_if_valid", if_valid, 0);
        chk1("rst_d_valid", d_valid, 0);
        chk1("rst_stall_F", stall_F, 0);
        chk1("rst_stall_M", stall_M, 0);
        if_req = 1; d_req = 1; mem_rvalid = 1;
        #1;
        chk1("rst_req_masked", mem_req, 0);
        chk1("rst_stall_F_follow", stall_F, 1);
        chk1("rst_stall_M_follow", stall_M, 1);
        chk1("rst_d_valid_masked", d_valid, 0);
        idle_inputs();

        // IDLE arbitration table
        for (int i = 0; i < 6; i++) begin
            step();
            RST_N = 1;
            d_req = vecs[i].d_req; if_req = vecs[i].if_req; d_we = vecs[i].d_we;
            if_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D; d_be = 4'h3;
            #2;
            chk1($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].exp_req);
            chk1($sformatf("vec%0d_stall_F", i), stall_F, vecs[i].exp_sf);
            chk1($sformatf("vec%0d_stall_M", i), stall_M, vecs[i].exp_sm);
            if (vecs[i].exp_req) begin
                chk32($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
                chk1($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].exp_we);
                chk32($sformatf("vec%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
                if (vecs[i].exp_we)
                    chk32($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            end
            RST_N = 0;
            idle_inputs();
        end

        // Fetch only, granted at once, response two cycles later
        step(); RST_N = 1;
        step(); if_req = 1; if_addr = 32'h100; mem_gnt = 1; #2;
        chk1("f1_c0_req", mem_req, 1);
        chk32("f1_c0_addr", mem_addr, 32'h100);
        chk32("f1_c0_be", 32'(mem_be), 32'hF);
        chk1("f1_c0_stall_F", stall_F, 1);
        step(); mem_gnt = 0; #2;
        chk1("f1_c1_req", mem_req, 0);
        chk1("f1_c1_stall_F", stall_F, 1);
        step(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #2;
        chk1("f1_c2_if_valid", if_valid, 1);
        chk32("f1_c2_if_rdata", if_rdata, 32'hDEADBEEF);
        chk1("f1_c2_stall_F", stall_F, 0);
        step(); mem_rvalid = 0; if_req = 0; #2;
        chk1("f1_c3_if_valid", if_valid, 0);

        // Load and fetch together: data first, fetch in the following IDLE
        step(); d_req = 1; d_addr = 32'h2000; if_req = 1; if_addr = 32'h100; mem_gnt = 1; #2;
        chk32("tie_first_addr", mem_addr, 32'h2000);
        chk1("tie_first_we", mem_we, 0);
        step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h11112222; #2;
        chk1("tie_d_valid", d_valid, 1);
        chk32("tie_d_rdata", d_rdata, 32'h11112222);
        chk1("tie_if_valid", if_valid, 0);
        chk1("tie_stall_F", stall_F, 1);
        step(); mem_rvalid = 0; d_req = 0; mem_gnt = 1; #2;
        chk32("tie_second_addr", mem_addr, 32'h100);
        step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h33334444; #2;
        chk1("tie_if_valid2", if_valid, 1);
        chk32("tie_if_rdata2", if_rdata, 32'h33334444);
        step(); idle_inputs(); #2;

        // Locked fetch, grant withheld, data arrives during REQ
        step(); if_req = 1; if_addr = 32'h140; #2;
        chk32("lock_c0_addr", mem_addr, 32'h140);
        step(); d_req = 1; d_addr = 32'h2000; #2;
        chk32("lock_c1_addr", mem_addr, 32'h140);
        step(); #2;
        chk32("lock_c2_addr", mem_addr, 32'h140);
        step(); mem_gnt = 1; #2;
        chk32("lock_gnt_addr", mem_addr, 32'h140);
        step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55556666; #2;
        chk1("lock_if_valid", if_valid, 1);
        chk1("lock_d_valid", d_valid, 0);
        step(); mem_rvalid = 0; if_req = 0; mem_gnt = 1; #2;
        chk32("lock_data_addr", mem_addr, 32'h2000);
        step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77778888; #2;
        chk1("lock_data_valid", d_valid, 1);
        chk32("lock_data_rdata", d_rdata, 32'h77778888);
        step(); idle_inputs(); #2;

        // Kill in WAIT, response two cycles later, then a normal refetch
        step(); if_req = 1; if_addr = 32'h180; mem_gnt = 1; #2;
        chk1("kill_issue", mem_req, 1);
        step(); mem_gnt = 0; if_kill = 1; #2;
        chk1("kill_wait_req", mem_req, 0);
        step(); if_kill = 0; #2;
        step(); mem_rvalid = 1; mem_rdata = 32'h99990000; #2;
        chk1("kill_suppressed", if_valid, 0);
        chk1("kill_stall_F", stall_F, 1);
        step(); mem_rvalid = 0; mem_gnt = 1; #2;
        chk1("kill_refetch_req", mem_req, 1);
        chk32("kill_refetch_addr", mem_addr, 32'h180);
        step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D; #2;
        chk1("kill_refetch_valid", if_valid, 1);
        chk32("kill_refetch_rdata", if_rdata, 32'h0BADF00D);

        // Kill together with the response, then reset while locked
        step(); mem_rvalid = 0; mem_gnt = 1; #2;
        step(); mem_gnt = 0; mem_rvalid = 1; if_kill = 1; #2;
        chk1("kill_same_cycle", if_valid, 0);
        step(); mem_rvalid = 0; if_kill = 0; #2;
        chk1("kill_back_idle", mem_req, 1);
        step(); RST_N = 0; #1; RST_N = 1;
        d_req = 1; d_we = 0; d_addr = 32'h2400; #1;
        chk32("reset_mid_tx_addr", mem_addr, 32'h2400);
        idle_inputs(); RST_N = 0;

        // Store with partial byte enables
        step(); RST_N = 1;
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hCAFEF00D; d_be = 4'b0011; mem_gnt = 1; #2;
        chk1("st_we", mem_we, 1);
        chk32("st_be", 32'(mem_be), 32'h3);
        chk32("st_wdata", mem_wdata, 32'hCAFEF00D);
        chk32("st_addr", mem_addr, 32'h3000);
        step(); mem_gnt = 0; mem_rvalid = 1; #2;
        chk1("st_d_valid", d_valid, 1);
        chk1("st_stall_M", stall_M, 0);
        step(); idle_inputs(); RST_N = 0;

        // Data held high with fetch pending
        step(); RST_N = 1;
        d_req = 1; d_we = 0; d_addr = 32'h2000; if_req = 1; if_addr = 32'h1C0;
        dgr = 0; fetch_at = -1; ifv_cnt = 0;
        for (int t = 0; t < 12; t++) begin
            step(); mem_rvalid = 0; mem_gnt = 1; #2;
            if (mem_req && mem_addr == 32'h1C0) begin
                if (fetch_at < 0) fetch_at = dgr;
            end else if (mem_req) begin
                dgr++;
            end
            step(); mem_gnt = 0; mem_rvalid = 1; #2;
            if (if_valid) ifv_cnt++;
        end
        chk32("starve_first_fetch", 32'(fetch_at), GUARD ? 32'd4 : 32'hFFFF_FFFF);
        chk32("starve_if_valid_cnt", 32'(ifv_cnt), GUARD ? 32'd2 : 32'd0);
        idle_inputs(); RST_N = 0;

        // Randomized traffic against the transaction model
        step(); RST_N = 1;
        m_phase = 0; m_owner = 0; m_kill = 0; m_lat = 0; m_streak = 0;
        f_done = 0; d_done = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (f_done) if_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_done) d_req = 0;
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                d_wdata = $urandom; d_be = 4'($urandom);
            end
            mem_gnt   = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            if (m_phase == 2) mem_rvalid = (m_lat == 0);
            else              mem_rvalid = ($urandom_range(0, 7) == 0);
            if (m_owner == 1 && m_phase != 0) if_kill = ($urandom_range(0, 5) == 0);
            else                              if_kill = ($urandom_range(0, 15) == 0);
            #2;

            if (GUARD && m_streak >= STARVE_MAX && if_req) win = 1;
            else if (d_req)  win = 2;
            else if (if_req) win = 1;
            else             win = 0;
            cur   = (m_phase == 0) ? win : m_owner;
            e_req = (m_phase == 0) ? (win != 0) : (m_phase == 1);
            rsp   = (m_phase == 2) && mem_rvalid;
            e_ifv = rsp && m_owner == 1 && m_kill == 0 && !if_kill;
            e_dv  = rsp && m_owner == 2;

            chk1("rnd_mem_req", mem_req, e_req);
            chk1("rnd_if_valid", if_valid, e_ifv);
            chk1("rnd_d_valid", d_valid, e_dv);
            chk1("rnd_stall_F", stall_F, if_req && !e_ifv);
            chk1("rnd_stall_M", stall_M, d_req && !e_dv);
            if (e_req) begin
                chk32("rnd_mem_addr", mem_addr, (cur == 2) ? d_addr : if_addr);
                chk1("rnd_mem_we", mem_we, (cur == 2) ? d_we : 1'b0);
                chk32("rnd_mem_be", 32'(mem_be), (cur == 2) ? 32'(d_be) : 32'hF);
                if (cur == 2 && d_we) chk32("rnd_mem_wdata", mem_wdata, d_wdata);
            end
            if (e_ifv) chk32("rnd_if_rdata", if_rdata, mem_rdata);
            if (e_dv && !d_we) chk32("rnd_d_rdata", d_rdata, mem_rdata);

            if (GUARD && e_req && mem_gnt) begin
                if (cur == 2 && if_req && m_streak < STARVE_MAX) m_streak++;
                if (cur == 1) m_streak = 0;
            end
            if (m_phase != 0 && m_owner == 1 && if_kill) m_kill = 1;
            case (m_phase)
                0: if (win != 0) begin
                       m_owner = win;
                       if (mem_gnt) begin m_phase = 2; m_lat = $urandom_range(0, 3); end
                       else m_phase = 1;
                   end
                1: if (mem_gnt) begin m_phase = 2; m_lat = $urandom_range(0, 3); end
                default: if (mem_rvalid) begin
                       m_phase = 0; m_owner = 0; m_kill = 0;
                   end else begin
                       m_lat--;
                   end
            endcase
            f_done = e_ifv;
            d_done = e_dv;
        end

        idle_inputs();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
